// File: rtl/div_pkg.sv
// div_pkg: shared constants and FSM encoding for the
// sequential signed divider and its multiplier peers.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] Q_DIVZERO  = '1;
  localparam logic [DIV_WIDTH-1:0] Q_OVERFLOW =
    {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on an
// already-shifted partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] b_abs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // rem_in carries WIDTH+1 bits so |b| = 2^(WIDTH-1) never loses a carry.
  // After a successful subtract the result is below |b|, so WIDTH bits hold it.
  assign q_bit   = rem_in >= {1'b0, b_abs};
  assign rem_out = q_bit ? WIDTH'(rem_in - {1'b0, b_abs})
                         : rem_in[WIDTH-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: 2W-bit by W-bit signed divider, one
// quotient bit per cycle, fixed latency start/busy/done.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   b_abs;
  logic               sign_q;
  logic               sign_r;
  logic               dz;
  logic               ovf_u;

  logic [2*WIDTH-1:0] a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               q_too_big;

  assign a_mag = a_reg[2*WIDTH-1] ? -a_reg : a_reg;
  assign b_mag = b_reg[WIDTH-1] ? -b_reg : b_reg;

  // Positive results may reach 2^(W-1)-1, negative ones 2^(W-1).
  assign q_too_big = sign_q ? (lo > MIN_MAG) : lo[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  ({rem, lo[WIDTH-1]}),
    .b_abs   (b_abs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem       <= '0;
      lo        <= '0;
      b_abs     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz        <= 1'b0;
      ovf_u     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          rem    <= a_mag[2*WIDTH-1:WIDTH];
          lo     <= a_mag[WIDTH-1:0];
          b_abs  <= b_mag;
          sign_q <= a_reg[2*WIDTH-1] ^ b_reg[WIDTH-1];
          sign_r <= a_reg[2*WIDTH-1];
          dz     <= (b_reg == '0);
          ovf_u  <= (b_reg != '0) &&
                    (a_mag[2*WIDTH-1:WIDTH] >= b_mag);
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          rem <= step_rem;
          lo  <= {lo[WIDTH-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient  <= Q_DIVZERO;
            remainder <= a_reg[WIDTH-1:0];
            overflow  <= 1'b0;
          end else if (ovf_u || q_too_big) begin
            quotient  <= Q_OVERFLOW;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= sign_q ? -lo : lo;
            remainder <= sign_r ? -rem : rem;
            overflow  <= 1'b0;
          end
          div_zero <= dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
